// File: rtl/count_seg_display.sv
// count_seg_display
//   Consumes the 4-bit counter's result bus. It checks that successive samples step by
//   +1 mod 16 and counts 15->0 wraps. It scans cur, the wrap count and the status onto a
//   4-digit active-low seven-segment display.
//
//   Build option: define SEQ_CHECK_EN to enable step checking (err, 'E' on digit 3).
//   Without it, err is tied low and digit 3 stays blank. Wrap counting is always active.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   count_in  in   [3:0] count value from the counter's result bus
//   load      in   sample strobe; count_in captured on rising clk with load=1
//   seg       out  [6:0] active-low segments, seg[0]=a .. seg[6]=g
//   an        out  [3:0] active-low digit enables, an[0] = rightmost digit
//   dp        out  active-low decimal point (lit on digit 2 once wraps overflowed)
//   wraps     out  [7:0] number of 15->0 wraps seen, mod 256
//   err       out  sticky sequence-error flag
module count_seg_display #(
    parameter int unsigned REFRESH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count_in,
    input  logic       load,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic [7:0] wraps,
    output logic       err
);

    localparam int unsigned CntW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CntW-1:0] RefreshLast = CntW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {StDig0, StDig1, StDig2, StDig3} scan_e;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ---------------- capture path ----------------
    logic [3:0] cur_q;
    logic [7:0] wraps_q;
    logic       primed_q;
    logic       wrap_ovf_q;
    logic       is_wrap;

    // The first sample after reset has no predecessor, so it can never count as a wrap.
    assign is_wrap = primed_q && (cur_q == 4'hF) && (count_in == 4'h0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_q      <= 4'h0;
            wraps_q    <= 8'h00;
            primed_q   <= 1'b0;
            wrap_ovf_q <= 1'b0;
        end else if (load) begin
            cur_q    <= count_in;
            primed_q <= 1'b1;
            if (is_wrap) begin
                wraps_q <= wraps_q + 8'd1;
                if (wraps_q == 8'hFF) begin
                    wrap_ovf_q <= 1'b1;
                end
            end
        end
    end

    assign wraps = wraps_q;

`ifdef SEQ_CHECK_EN
    logic err_q;
    logic seq_bad;

    // A repeat and a +1 step (which includes F->0) are legal. Anything else is an error.
    assign seq_bad = primed_q && (count_in != cur_q) && (count_in != 4'(cur_q + 4'd1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (load && seq_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // ---------------- scan FSM ----------------
    scan_e            state_q, state_d;
    logic [CntW-1:0]  refresh_q, refresh_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StDig0;
            refresh_q <= '0;
        end else begin
            state_q   <= state_d;
            refresh_q <= refresh_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        refresh_d = refresh_q + CntW'(1);
        an        = 4'b1110;
        seg       = 7'b1111111;
        dp        = 1'b1;

        if (refresh_q == RefreshLast) begin
            refresh_d = '0;
            unique case (state_q)
                StDig0:  state_d = StDig1;
                StDig1:  state_d = StDig2;
                StDig2:  state_d = StDig3;
                default: state_d = StDig0;
            endcase
        end

        // Display is a pure decode of registered state, so a capture shows up immediately.
        unique case (state_q)
            StDig0: begin
                an  = 4'b1110;
                seg = hex_seg(cur_q);
            end
            StDig1: begin
                an  = 4'b1101;
                seg = hex_seg(wraps_q[3:0]);
            end
            StDig2: begin
                an  = 4'b1011;
                seg = hex_seg(wraps_q[7:4]);
                dp  = ~wrap_ovf_q;
            end
            default: begin
                an  = 4'b0111;
                seg = err ? 7'b0000110 : 7'b1111111;
            end
        endcase
    end

endmodule

// File: tb/tb_count_seg_display.sv
// Self-checking bench for count_seg_display (REFRESH_CYCLES = 4).
// The stimulus tasks update a small behavioural model and push expected snapshots into a
// queue. A monitor pops each snapshot and compares it on the following falling clk edge,
// or on an explicit sample event when the check must happen between clk edges.
module tb_count_seg_display;

`ifdef SEQ_CHECK_EN
    localparam bit Chk = 1'b1;
`else
    localparam bit Chk = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] count_in;
    logic       load;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic [7:0] wraps;
    logic       err;

    count_seg_display #(.REFRESH_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .count_in (count_in),
        .load     (load),
        .seg      (seg),
        .an       (an),
        .dp       (dp),
        .wraps    (wraps),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [7:0] wraps;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    event sample_ev;

    // Rising edges since the last reset release; selects the expected digit.
    int tb_cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    // Behavioural model of the capture state.
    logic [3:0] m_cur;
    logic [7:0] m_wraps;
    logic       m_ovf, m_err, m_primed;

    function automatic logic [6:0] hseg(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[v];
    endfunction

    task automatic reset_model();
        m_cur = 4'h0; m_wraps = 8'h00; m_ovf = 1'b0; m_err = 1'b0; m_primed = 1'b0;
    endtask

    task automatic push_exp(input string name);
        exp_t e;
        int   dig;
        dig     = (tb_cyc / 4) % 4;
        e.name  = name;
        e.wraps = m_wraps;
        e.err   = m_err;
        e.dp    = 1'b1;
        case (dig)
            0:       begin e.an = 4'b1110; e.seg = hseg(m_cur); end
            1:       begin e.an = 4'b1101; e.seg = hseg(m_wraps[3:0]); end
            2:       begin e.an = 4'b1011; e.seg = hseg(m_wraps[7:4]); e.dp = ~m_ovf; end
            default: begin e.an = 4'b0111; e.seg = m_err ? 7'b0000110 : 7'b1111111; end
        endcase
        q.push_back(e);
    endtask

    // Monitor: compare every queued expectation against the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if ({an, seg, dp, wraps, err} !== {e.an, e.seg, e.dp, e.wraps, e.err}) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got an=%b seg=%b dp=%b wraps=%h err=%b, want an=%b seg=%b dp=%b wraps=%h err=%b",
                             e.name, $time, an, seg, dp, wraps, err,
                             e.an, e.seg, e.dp, e.wraps, e.err);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        reset_model();
        repeat (3) begin
            @(posedge clk); #1;
            push_exp("reset_hold");
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic do_load(input logic [3:0] v, input bit chk, input string name);
        @(negedge clk);
        count_in = v;
        load     = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        if (m_primed) begin
            if (v == m_cur) begin
            end else if (m_cur == 4'hF && v == 4'h0) begin
                if (m_wraps == 8'hFF) m_ovf = 1'b1;
                m_wraps = m_wraps + 8'd1;
            end else if (v == 4'(m_cur + 4'd1)) begin
            end else if (Chk) begin
                m_err = 1'b1;
            end
        end
        m_cur    = v;
        m_primed = 1'b1;
        if (chk) push_exp(name);
    endtask

    task automatic idle(input int n, input string name);
        repeat (n) begin
            @(posedge clk); #1;
            push_exp(name);
        end
    endtask

    // Assumes the model is at cur=0: loads 1..F,0 n times, i.e. n wraps.
    task automatic run_wraps(input int n);
        for (int k = 0; k < n; k++) begin
            for (int v = 1; v <= 16; v++) do_load(4'(v), 1'b0, "wrap_run");
        end
    endtask

    initial begin
        reset    = 1'b0;
        load     = 1'b0;
        count_in = 4'h0;
        reset_model();

        // 1: reset state and hold until the first load
        repeat (3) begin
            @(posedge clk); #1;
            push_exp("t1_in_reset");
        end
        @(negedge clk);
        reset = 1'b1;
        idle(18, "t1_idle");

        // 2: 0..F,0 gives one wrap; idle through every digit slot
        for (int v = 0; v <= 16; v++) do_load(4'(v), 1'b1, "t2_seq");
        idle(16, "t2_scan");

        // 3: load 5, then watch the scan order and slot lengths
        do_reset();
        do_load(4'h5, 1'b1, "t3_load5");
        idle(32, "t3_scan");

        // 4: a repeat is legal, a jump is sticky-err
        do_reset();
        do_load(4'h3, 1'b1, "t4_load3");
        do_load(4'h3, 1'b1, "t4_repeat3");
        idle(4, "t4_after_repeat");
        do_load(4'h7, 1'b1, "t4_jump7");
        do_load(4'h8, 1'b1, "t4_legal8");
        do_load(4'h9, 1'b1, "t4_legal9");
        idle(16, "t4_scan_err");

        // 5: 256 full cycles overflow wraps back to 00 and light dp on digit 2
        do_reset();
        do_load(4'h0, 1'b1, "t5_first0");
        run_wraps(256);
        idle(20, "t5_ovf_scan");

        // 6: asynchronous reset mid-scan with wraps=2A and err set
        do_reset();
        do_load(4'h0, 1'b1, "t6_first0");
        run_wraps(42);
        do_load(4'h5, 1'b1, "t6_bad5");
        idle(6, "t6_pre_reset");
        @(posedge clk); #3;
        reset = 1'b0;
        reset_model();
        #1;
        push_exp("t6_async_reset");
        ->sample_ev;
        #1;
        @(negedge clk);
        reset = 1'b1;
        do_load(4'h9, 1'b1, "t6_unchecked9");
        do_load(4'hA, 1'b1, "t6_legalA");
        idle(16, "t6_scan");

        @(negedge clk); #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
